// File: rtl/ring_osc_meter.sv
`default_nettype none
// ============================================================================
// Module   : ring_osc_meter
// Desc     : Enables a ring oscillator, then counts its synchronized rising
//            edges over a fixed clk window. RO_CNT_SAT_EN: saturating count.
// Revision : 1.0
// ============================================================================
module ring_osc_meter #(
  parameter int GATE_CYCLES   = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             osc,
  output logic             ring_nrst,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  localparam int c_TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX);
  localparam logic [c_TMR_W-1:0] c_SETTLE_LOAD = c_TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_GATE_LOAD   = c_TMR_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_TMR_W-1:0] w_tmr_nxt;
  logic [CNT_W-1:0]   r_acc;
  logic [CNT_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_acc_inc;
  logic               r_ovf;
  logic               w_ovf_nxt;

  logic r_s1;
  logic r_s2;
  logic r_sp;
  logic w_edge;

  logic             r_ring_nrst;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic [CNT_W-1:0] r_count;

  // Synchronizer and edge detector run in every state so they are already
  // filled with valid history when the window opens.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_sp <= 1'b0;
    end else begin
      r_s1 <= osc;
      r_s2 <= r_s1;
      r_sp <= r_s2;
    end
  end

  assign w_edge = r_s2 & ~r_sp;

`ifdef RO_CNT_SAT_EN
  assign w_acc_inc = (r_acc == '1) ? r_acc : r_acc + 1'b1;
`else
  assign w_acc_inc = r_acc + 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SETTLE;
          w_tmr_nxt   = c_SETTLE_LOAD;
          w_acc_nxt   = '0;
          w_ovf_nxt   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (r_tmr == '0) begin
          w_state_nxt = S_MEASURE;
          w_tmr_nxt   = c_GATE_LOAD;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      S_MEASURE: begin
        // The final window cycle still counts its edge before DONE latches.
        if (w_edge) begin
          if (r_acc == '1) begin
            w_ovf_nxt = 1'b1;
          end
          w_acc_nxt = w_acc_inc;
        end
        if (r_tmr == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_acc   <= w_acc_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // Outputs are flopped from the next-state decode so they line up with the
  // state register while still coming straight out of flops.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ring_nrst <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_count     <= '0;
    end else begin
      r_ring_nrst <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        r_count    <= w_acc_nxt;
        r_overflow <= w_ovf_nxt;
      end
    end
  end

  assign ring_nrst = r_ring_nrst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: doc/ring_osc_meter.md
# ring_osc_meter

Measurement controller at the far end of the ring-oscillator macro. It enables the ring through its active-low reset, lets it settle, and counts synchronized rising edges of the ring output over a fixed window of `clk` cycles. It then latches the count and disables the ring again. The block sits in the `clk` domain beside the ring and gives the top level a start/done measurement interface with a parallel result.

## Interface

Parameters:
- `GATE_CYCLES`, 256 — length of the measurement window in `clk` cycles (≥2).
- `SETTLE_CYCLES`, 16 — cycles between enabling the ring and opening the window (≥3, covers synchronizer fill).
- `CNT_W`, 16 — width of the edge accumulator and result.

Ports:
- `clk`  in  1  — single block clock.
- `nrst`  in  1  — reset, asynchronous, active-low.
- `start`  in  1  — request a measurement; sampled only in IDLE.
- `osc`  in  1  — ring output; asynchronous to `clk`.
- `ring_nrst`  out  1  — drives the ring's `nrst`; high enables oscillation.
- `busy`  out  1  — high from start acceptance until the DONE cycle (inclusive).
- `done`  out  1  — one-cycle pulse when `count` updates.
- `overflow`  out  1  — last measurement exceeded `2^CNT_W-1` edges.
- `count`  out  CNT_W  — latched edge count of the last completed measurement.

## Operation

- Reset values: FSM=IDLE, `ring_nrst`=0, `busy`=0, `done`=0, `overflow`=0, `count`=0. The synchronizer, edge register, accumulator and timer are all 0.
- `osc` passes through a 2-flop synchronizer (`s1`,`s2`) and a previous-value flop `sp`. Edge = `s2 & ~sp`. These flops run continuously and are reset only by `nrst`.
- FSM states:
  - IDLE: `ring_nrst`=0. On `start`=1, go to SETTLE, load timer=`SETTLE_CYCLES-1`, clear the accumulator and the internal overflow flag.
  - SETTLE: `ring_nrst`=1. Timer decrements. At timer=0, go to MEASURE and load timer=`GATE_CYCLES-1`.
  - MEASURE: `ring_nrst`=1. Each cycle with edge=1 increments the accumulator. At timer=0, that cycle's edge is still counted; go to DONE.
  - DONE: `ring_nrst`=0. `count`←accumulator and `overflow`←internal flag. `done`=1 for this cycle only. Next state is IDLE.
- `busy`=1 in SETTLE, MEASURE and DONE.
- `start` outside IDLE is ignored and is not queued. `start` held high retriggers on the first IDLE cycle after DONE.
- Accumulator: CNT_W-bit unsigned. An increment at all-ones sets the internal overflow flag. The wrap or saturate behaviour follows the Configuration section.
- `count` and `overflow` hold their values between DONE cycles and are unaffected by a new start until that run's DONE.
- `nrst` asserted mid-measurement aborts immediately: all outputs return to their reset values and no `done` is produced.

## Timing

- Start accepted at cycle edge T0: `ring_nrst` and `busy` rise after T0.
- Window = exactly `GATE_CYCLES` MEASURE cycles.
- DONE occurs `SETTLE_CYCLES+GATE_CYCLES` cycles after T0, and `count` is valid in the same cycle `done`=1.
- Total `busy` duration is `SETTLE_CYCLES+GATE_CYCLES+1` cycles. A new start is accepted at the earliest one cycle after DONE.
- `osc` rise to counted edge takes 2–3 `clk` cycles; an edge is counted iff its detection cycle falls inside MEASURE.
- Countable frequency is at most `clk`/2. Faster rings alias and must be divided externally.
- All outputs are registered.

## Configuration

- `RO_CNT_SAT_EN` defined: the accumulator saturates at `2^CNT_W-1` and `overflow` is still set.
- Undefined: the accumulator wraps modulo `2^CNT_W` and `overflow` is set.
- `overflow` semantics are identical in both cases.

## Test plan

- Reset: hold `nrst`=0 with `start`=1 and `osc` toggling → all outputs 0 and no `done`. Release → a measurement starts on the first cycle.
- Nominal: `GATE_CYCLES`=64, `SETTLE_CYCLES`=4, `CNT_W`=8. Bench toggles `osc` every 4 clk while `ring_nrst`=1 → `done` at T0+68, `count`=8, `overflow`=0, `busy` high for 69 cycles.
- Overflow: `CNT_W`=4, `osc` toggles every clk (32 edges per window) → without `RO_CNT_SAT_EN`, `count`=0 and `overflow`=1. With `RO_CNT_SAT_EN`, `count`=15 and `overflow`=1.
- Ignored start: pulse `start` during MEASURE → no extra run. A second `done` only after a fresh `start` in IDLE, and the previous `count` holds until then.
- Abort: assert `nrst` mid-MEASURE → `ring_nrst`=0, `count`=0, no `done`. Next full run returns the correct value (8 with the nominal stimulus).
- Idle ring: `osc` stuck at 0 → `count`=0, `overflow`=0. `osc` stuck at 1 from before start → `count`=0 (no edge).
